// File: rtl/ctl_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctl_seq_pkg
//  Description : Shared next-address select encodings for the micro-program
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctl_seq_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_INC  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_JUMP = 3'd1;
    localparam logic [SEL_W-1:0] SEL_MAP  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_CALL = 3'd3;
    localparam logic [SEL_W-1:0] SEL_RET  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_CJMP = 3'd5;
    localparam logic [SEL_W-1:0] SEL_HOLD = 3'd6;
    localparam logic [SEL_W-1:0] SEL_RSVD = 3'd7;

endpackage : ctl_seq_pkg
`default_nettype wire

// File: rtl/ctl_seq_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ctl_seq_stack
//  Description : LIFO return-address stack for micro-subroutines. Pushing
//                while full and popping while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctl_seq_stack #(
    parameter int AW          = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_data,
    output logic [AW-1:0] o_top,
    output logic          o_empty,
    output logic          o_full
);

    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam int IW  = $clog2(STACK_DEPTH);

    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_mem [STACK_DEPTH];

    logic           w_do_push;
    logic           w_do_pop;
    logic [SPW-1:0] w_sp_m1;

    assign o_empty   = (r_sp == '0);
    assign o_full    = (r_sp == SPW'(STACK_DEPTH));
    // Push has priority so a (never expected) simultaneous request cannot
    // corrupt the pointer.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~i_push & ~o_empty;
    assign w_sp_m1   = r_sp - SPW'(1);
    assign o_top     = r_mem[w_sp_m1[IW-1:0]];

    // Stack pointer: increments on accepted push, decrements on accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SPW'(1);
        end else if (w_do_pop) begin
            r_sp <= w_sp_m1;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_sp[IW-1:0]] <= i_data;
        end
    end

endmodule : ctl_seq_stack
`default_nettype wire

// File: rtl/ctl_seq_next_addr.sv
`default_nettype none
// ============================================================================
//  Module      : ctl_seq_next_addr
//  Description : Micro-program sequencer: registers the micro-PC and selects
//                its next value from increment, jump, map, conditional jump,
//                call and return sources, with stall and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctl_seq_next_addr
    import ctl_seq_pkg::*;
#(
    parameter int          AW          = 16,
    parameter int          STACK_DEPTH = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_cond,
    input  logic             i_stall,
    input  logic [AW-1:0]    i_map_addr,
    input  logic [AW-1:0]    i_jump_addr,
    input  logic             i_err_clr,
    output logic [AW-1:0]    o_upc,
    output logic [AW-1:0]    o_next_upc,
    output logic             o_stack_empty,
    output logic             o_stack_full,
    output logic             o_err_ovf,
    output logic             o_err_unf
);

    logic [AW-1:0] r_upc;
    logic          r_err_ovf;
    logic          r_err_unf;

    logic [AW-1:0] w_inc;
    logic [AW-1:0] w_next;
    logic [AW-1:0] w_top;
    logic          w_push;
    logic          w_pop;
    logic          w_set_ovf;
    logic          w_set_unf;
    logic          w_empty;
    logic          w_full;

    assign w_inc = r_upc + AW'(1);

    ctl_seq_stack #(
        .AW          (AW),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_inc),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Next-address mux; stall forces a hold and suppresses stack/error side effects.
    always_comb begin
        w_next    = r_upc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (!i_stall) begin
            case (i_sel)
                SEL_INC:  w_next = w_inc;
                SEL_JUMP: w_next = i_jump_addr;
                SEL_MAP:  w_next = i_map_addr;
                SEL_CALL: begin
                    if (w_full) begin
                        w_next    = w_inc;
                        w_set_ovf = 1'b1;
                    end else begin
                        w_next = i_jump_addr;
                        w_push = 1'b1;
                    end
                end
                SEL_RET: begin
                    if (w_empty) begin
                        w_next    = w_inc;
                        w_set_unf = 1'b1;
                    end else begin
                        w_next = w_top;
                        w_pop  = 1'b1;
                    end
                end
                SEL_CJMP: w_next = i_cond ? i_jump_addr : w_inc;
                SEL_HOLD: w_next = r_upc;
                default:  w_next = i_jump_addr;   // reserved encoding acts as JUMP
            endcase
        end
    end

    // Micro-PC register; w_next already equals r_upc when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc <= RESET_ADDR;
        end else begin
            r_upc <= w_next;
        end
    end

    // Sticky error flags: a new error beats a clear; clear works even when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_err_ovf <= w_set_ovf | (r_err_ovf & ~i_err_clr);
            r_err_unf <= w_set_unf | (r_err_unf & ~i_err_clr);
        end
    end

    assign o_upc         = r_upc;
    assign o_next_upc    = w_next;
    assign o_stack_empty = w_empty;
    assign o_stack_full  = w_full;
    assign o_err_ovf     = r_err_ovf;
    assign o_err_unf     = r_err_unf;

endmodule : ctl_seq_next_addr
`default_nettype wire

// File: tb/tb_ctl_seq_next_addr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctl_seq_next_addr
//  Description : Self-checking bench for the micro-program sequencer, using
//                directed scenarios plus randomized traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctl_seq_next_addr;

    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [2:0]    i_sel;
    logic          i_cond;
    logic          i_stall;
    logic [AW-1:0] i_map_addr;
    logic [AW-1:0] i_jump_addr;
    logic          i_err_clr;
    logic [AW-1:0] o_upc;
    logic [AW-1:0] o_next_upc;
    logic          o_stack_empty;
    logic          o_stack_full;
    logic          o_err_ovf;
    logic          o_err_unf;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [AW-1:0] m_upc;
    logic [AW-1:0] m_stack[$];
    logic          m_ovf;
    logic          m_unf;

    ctl_seq_next_addr #(
        .AW          (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (16'h0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sel         (i_sel),
        .i_cond        (i_cond),
        .i_stall       (i_stall),
        .i_map_addr    (i_map_addr),
        .i_jump_addr   (i_jump_addr),
        .i_err_clr     (i_err_clr),
        .o_upc         (o_upc),
        .o_next_upc    (o_next_upc),
        .o_stack_empty (o_stack_empty),
        .o_stack_full  (o_stack_full),
        .o_err_ovf     (o_err_ovf),
        .o_err_unf     (o_err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string where);
        check_val({where, " upc"},   32'(o_upc), 32'(m_upc));
        check_val({where, " empty"}, 32'(o_stack_empty), 32'(m_stack.size() == 0));
        check_val({where, " full"},  32'(o_stack_full), 32'(m_stack.size() == DEPTH));
        check_val({where, " ovf"},   32'(o_err_ovf), 32'(m_ovf));
        check_val({where, " unf"},   32'(o_err_unf), 32'(m_unf));
    endtask

    // Asynchronous reset applied away from any clock edge; checked before the next edge.
    task automatic do_reset();
        i_sel = 3'd6; i_stall = 1'b0; i_err_clr = 1'b0; i_cond = 1'b0;
        rst_n = 1'b0;
        #1;
        m_upc = 16'h0000; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs (called at posedge+1), check prefetch, then registered state.
    task automatic drive(input logic [2:0] s, input logic c, input logic st,
                         input logic [AW-1:0] m, input logic [AW-1:0] j, input logic clr);
        logic [AW-1:0] inc;
        logic [AW-1:0] nxt;
        bit push, pop, so, su;
        push = 0; pop = 0; so = 0; su = 0;
        i_sel = s; i_cond = c; i_stall = st; i_map_addr = m; i_jump_addr = j; i_err_clr = clr;
        #1;
        inc = m_upc + 16'd1;
        nxt = m_upc;
        if (!st) begin
            case (s)
                3'd0: nxt = inc;
                3'd2: nxt = m;
                3'd3: if (m_stack.size() == DEPTH) begin nxt = inc; so = 1; end
                      else begin nxt = j; push = 1; end
                3'd4: if (m_stack.size() == 0) begin nxt = inc; su = 1; end
                      else begin nxt = m_stack[$]; pop = 1; end
                3'd5: nxt = c ? j : inc;
                3'd6: nxt = m_upc;
                default: nxt = j;
            endcase
        end
        check_val("next_upc", 32'(o_next_upc), 32'(nxt));
        @(posedge clk);
        #1;
        if (push) m_stack.push_back(inc);
        if (pop)  void'(m_stack.pop_back());
        m_upc = nxt;
        m_ovf = so | (m_ovf & ~clr);
        m_unf = su | (m_unf & ~clr);
        check_state("cycle");
    endtask

    initial begin
        rst_n = 1'b0; i_sel = 3'd6; i_cond = 1'b0; i_stall = 1'b0;
        i_map_addr = '0; i_jump_addr = '0; i_err_clr = 1'b0;
        m_upc = '0; m_ovf = 1'b0; m_unf = 1'b0;
        #3;
        do_reset();

        // 1: three increments, then reset mid-sequence
        repeat (3) drive(3'd0, 0, 0, 16'h0, 16'h0, 0);
        check_val("inc3 upc", 32'(o_upc), 32'h3);
        i_sel = 3'd0;
        do_reset();

        // 2: call / return round trip
        drive(3'd1, 0, 0, 16'h0, 16'h0010, 0);
        drive(3'd3, 0, 0, 16'h0, 16'h0100, 0);
        check_val("call target", 32'(o_upc), 32'h0100);
        drive(3'd0, 0, 0, 16'h0, 16'h0, 0);
        drive(3'd0, 0, 0, 16'h0, 16'h0, 0);
        drive(3'd4, 0, 0, 16'h0, 16'h0, 0);
        check_val("ret addr", 32'(o_upc), 32'h0011);
        check_val("ret empty", 32'(o_stack_empty), 32'h1);

        // 3: nested calls to overflow, then LIFO unwind
        for (int k = 0; k < 5; k++) drive(3'd3, 0, 0, 16'h0, 16'(16'h0200 + 16'(k * 16)), 0);
        check_val("ovf flag", 32'(o_err_ovf), 32'h1);
        for (int k = 0; k < 4; k++) drive(3'd4, 0, 0, 16'h0, 16'h0, 0);
        check_val("unwind empty", 32'(o_stack_empty), 32'h1);
        drive(3'd0, 0, 0, 16'h0, 16'h0, 1);

        // 4: underflow, clear collision, lone clear
        drive(3'd1, 0, 0, 16'h0, 16'h0020, 0);
        drive(3'd4, 0, 0, 16'h0, 16'h0, 0);
        check_val("unf upc", 32'(o_upc), 32'h0021);
        drive(3'd4, 0, 0, 16'h0, 16'h0, 1);
        check_val("unf set wins", 32'(o_err_unf), 32'h1);
        drive(3'd6, 0, 0, 16'h0, 16'h0, 1);
        check_val("unf cleared", 32'(o_err_unf), 32'h0);

        // 5: conditional jump, map, reserved select
        drive(3'd5, 0, 0, 16'h0, 16'h0040, 0);
        drive(3'd5, 1, 0, 16'h0, 16'h0040, 0);
        drive(3'd2, 0, 0, 16'h0A00, 16'h0, 0);
        drive(3'd7, 0, 0, 16'h0, 16'h1234, 0);

        // 6: stall during a call at the wrap boundary
        drive(3'd1, 0, 0, 16'h0, 16'hFFFF, 0);
        repeat (3) drive(3'd3, 0, 1, 16'h0, 16'h0300, 0);
        drive(3'd3, 0, 0, 16'h0, 16'h0300, 0);
        drive(3'd4, 0, 0, 16'h0, 16'h0, 0);
        check_val("wrap ret", 32'(o_upc), 32'h0000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom),
                      ($urandom_range(0, 9) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ctl_seq_next_addr
`default_nettype wire
